// File: rtl/div_pkg.sv
// Shared definitions for the restoring divider: FSM encoding and default widths.
package div_pkg;

    localparam int DW_DEF = 8;
    localparam int VW_DEF = 4;
    localparam int CNT_W  = $clog2(DW_DEF + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_e;

    // Iteration counter width for an arbitrary dividend width.
    function automatic int cnt_width(input int dw);
        return $clog2(dw + 1);
    endfunction

endpackage

// File: rtl/restoring_divider_if.sv
// Request/result bundle between a divider client (master) and the divider (slave).
// Handshake: start is a request sampled on a rising edge; it is taken only when
// busy is low (state IDLE or DONE), otherwise it is dropped, not queued. done is
// a one-cycle pulse marking quotient/remainder/div_by_zero valid; those outputs
// then hold until the next accepted start.
interface restoring_divider_if
    import div_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int VW = VW_DEF
) ();

    logic          start;
    logic [DW-1:0] dividend;
    logic [VW-1:0] divisor;
    logic          busy;
    logic          done;
    logic          div_by_zero;
    logic [DW-1:0] quotient;
    logic [VW-1:0] remainder;
    div_state_e    state;

    modport master (
        output start, dividend, divisor,
        input  busy, done, div_by_zero, quotient, remainder, state
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, div_by_zero, quotient, remainder, state
    );

endinterface

// File: rtl/div_step.sv
// One restoring-division iteration: shift in the next dividend bit, subtract the
// divisor if it fits, and report the resulting quotient bit.
module div_step #(
    parameter int VW = 4
) (
    input  logic [VW:0]   pr,
    input  logic          dvd_msb,
    input  logic [VW-1:0] divisor,
    output logic [VW:0]   pr_next,
    output logic          q_bit
);

    logic [VW:0] shifted;

    // pr[VW] set would mean the shifted value overflowed VW+1 bits, so it always fits.
    always_comb begin
        shifted = {pr[VW-1:0], dvd_msb};
        q_bit   = pr[VW] | (shifted >= {1'b0, divisor});
        pr_next = q_bit ? (shifted - {1'b0, divisor}) : shifted;
    end

endmodule

// File: rtl/restoring_divider.sv
// Sequential unsigned radix-2 restoring divider, one quotient bit per clock, MSB first.
// The dividend register doubles as the quotient register: each cycle its MSB is
// consumed and the new quotient bit enters at the LSB.
module restoring_divider
    import div_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int VW = VW_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    restoring_divider_if.slave bus
);

    localparam int          CW   = cnt_width(DW);
    localparam logic [CW-1:0] LAST = CW'(DW - 1);

    div_state_e    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [VW:0]   pr_q, pr_d;
    logic [DW-1:0] dvd_q, dvd_d;
    logic [VW-1:0] dvs_q, dvs_d;
    logic [DW-1:0] quo_q, quo_d;
    logic [VW-1:0] rem_q, rem_d;
    logic          done_q, done_d;
    logic          dbz_q, dbz_d;

    logic [VW:0]   step_pr;
    logic          step_q;

    div_step #(.VW(VW)) u_step (
        .pr      (pr_q),
        .dvd_msb (dvd_q[DW-1]),
        .divisor (dvs_q),
        .pr_next (step_pr),
        .q_bit   (step_q)
    );

    // State and datapath registers; async reset clears everything, aborting any run.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            pr_q    <= '0;
            dvd_q   <= '0;
            dvs_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pr_q    <= pr_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            done_q  <= done_d;
            dbz_q   <= dbz_d;
        end
    end

    // Next state and datapath: accept in IDLE/DONE, iterate in RUN, publish on the last step.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pr_d    = pr_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        done_d  = 1'b0;
        dbz_d   = dbz_q;
        case (state_q)
            RUN: begin
                pr_d  = step_pr;
                dvd_d = {dvd_q[DW-2:0], step_q};
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    state_d = DONE;
                    quo_d   = {dvd_q[DW-2:0], step_q};
                    rem_d   = step_pr[VW-1:0];
                    done_d  = 1'b1;
                end
            end
            default: begin
                if (bus.start) begin
                    if (bus.divisor == '0) begin
                        state_d = DONE;
                        quo_d   = '1;
                        rem_d   = '0;
                        done_d  = 1'b1;
                        dbz_d   = 1'b1;
                    end else begin
                        state_d = RUN;
                        dvd_d   = bus.dividend;
                        dvs_d   = bus.divisor;
                        pr_d    = '0;
                        cnt_d   = '0;
                        dbz_d   = 1'b0;
                    end
                end
            end
        endcase
    end

    // Outputs: busy decodes the RUN state, results come straight from their registers.
    always_comb begin
        bus.busy        = (state_q == RUN);
        bus.done        = done_q;
        bus.div_by_zero = dbz_q;
        bus.quotient    = quo_q;
        bus.remainder   = rem_q;
        bus.state       = state_q;
    end

endmodule

// File: tb/tb_restoring_divider.sv
// Directed bench for restoring_divider: latency window, results, divide-by-zero,
// ignored starts, back-to-back accept and reset abort.
module tb_restoring_divider;
    import div_pkg::*;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    restoring_divider_if #(.DW(8), .VW(4)) dut_bus ();

    restoring_divider #(.DW(8), .VW(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (dut_bus)
    );

    // Clock: 10 ns period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance to 1 ns after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a start for one edge; returns 1 ns after the sampling edge.
    task automatic issue(input logic [7:0] dvd, input logic [3:0] dvs);
        dut_bus.start    = 1'b1;
        dut_bus.dividend = dvd;
        dut_bus.divisor  = dvs;
        tick();
        dut_bus.start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n            = 1'b0;
        dut_bus.start    = 1'b0;
        dut_bus.dividend = '0;
        dut_bus.divisor  = '0;
        tick();
        tick();
        checks++;
        if ({dut_bus.busy, dut_bus.done, dut_bus.div_by_zero} !== 3'b000 ||
            dut_bus.quotient !== 8'd0 || dut_bus.remainder !== 4'd0 || dut_bus.state !== IDLE) begin
            errors++;
            $display("FAIL reset_values busy=%b done=%b dbz=%b q=%0d r=%0d st=%0d expected all 0 / IDLE",
                     dut_bus.busy, dut_bus.done, dut_bus.div_by_zero, dut_bus.quotient,
                     dut_bus.remainder, dut_bus.state);
        end
        #2 rst_n = 1'b1;
        tick();
        checks++;
        if (dut_bus.busy !== 1'b0 || dut_bus.done !== 1'b0) begin
            errors++;
            $display("FAIL reset_release busy=%b done=%b expected 0 0", dut_bus.busy, dut_bus.done);
        end
    endtask

    task automatic test_basic();
        issue(8'd200, 4'd7);
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (dut_bus.busy !== 1'b1 || dut_bus.done !== 1'b0 || dut_bus.quotient !== 8'd0) begin
                errors++;
                $display("FAIL basic_window k=%0d busy=%b done=%b q=%0d expected busy=1 done=0 q=0",
                         k, dut_bus.busy, dut_bus.done, dut_bus.quotient);
            end
            if (k < 7) tick();
        end
        tick();
        checks++;
        if ({dut_bus.done, dut_bus.busy, dut_bus.div_by_zero} !== 3'b100 ||
            dut_bus.quotient !== 8'd28 || dut_bus.remainder !== 4'd4) begin
            errors++;
            $display("FAIL basic_result done=%b busy=%b dbz=%b q=%0d r=%0d expected 1 0 0 q=28 r=4",
                     dut_bus.done, dut_bus.busy, dut_bus.div_by_zero, dut_bus.quotient, dut_bus.remainder);
        end
        tick();
        checks++;
        if (dut_bus.done !== 1'b0 || dut_bus.quotient !== 8'd28 || dut_bus.remainder !== 4'd4) begin
            errors++;
            $display("FAIL basic_hold done=%b q=%0d r=%0d expected done=0 q=28 r=4",
                     dut_bus.done, dut_bus.quotient, dut_bus.remainder);
        end
    endtask

    task automatic test_latency_pair();
        logic [7:0] dvd [2];
        logic [3:0] dvs [2];
        logic [7:0] eq  [2];
        logic [3:0] er  [2];
        dvd[0] = 8'd255; dvs[0] = 4'd15; eq[0] = 8'd17; er[0] = 4'd0;
        dvd[1] = 8'd0;   dvs[1] = 4'd5;  eq[1] = 8'd0;  er[1] = 4'd0;
        for (int t = 0; t < 2; t++) begin
            issue(dvd[t], dvs[t]);
            for (int k = 1; k < 8; k++) begin
                tick();
                checks++;
                if (dut_bus.done !== 1'b0 || dut_bus.busy !== 1'b1) begin
                    errors++;
                    $display("FAIL pair_window t=%0d k=%0d done=%b busy=%b expected done=0 busy=1",
                             t, k, dut_bus.done, dut_bus.busy);
                end
            end
            tick();
            checks++;
            if (dut_bus.done !== 1'b1 || dut_bus.busy !== 1'b0 ||
                dut_bus.quotient !== eq[t] || dut_bus.remainder !== er[t]) begin
                errors++;
                $display("FAIL pair_result t=%0d done=%b busy=%b q=%0d r=%0d expected 1 0 q=%0d r=%0d",
                         t, dut_bus.done, dut_bus.busy, dut_bus.quotient, dut_bus.remainder, eq[t], er[t]);
            end
            tick();
        end
    endtask

    task automatic test_div_by_zero();
        issue(8'd9, 4'd0);
        checks++;
        if ({dut_bus.done, dut_bus.div_by_zero, dut_bus.busy} !== 3'b110 ||
            dut_bus.quotient !== 8'hFF || dut_bus.remainder !== 4'd0) begin
            errors++;
            $display("FAIL dbz_result done=%b dbz=%b busy=%b q=%h r=%0d expected 1 1 0 q=ff r=0",
                     dut_bus.done, dut_bus.div_by_zero, dut_bus.busy, dut_bus.quotient, dut_bus.remainder);
        end
        tick();
        checks++;
        if (dut_bus.done !== 1'b0 || dut_bus.div_by_zero !== 1'b1 || dut_bus.quotient !== 8'hFF) begin
            errors++;
            $display("FAIL dbz_hold done=%b dbz=%b q=%h expected done=0 dbz=1 q=ff",
                     dut_bus.done, dut_bus.div_by_zero, dut_bus.quotient);
        end
        issue(8'd13, 4'd4);
        checks++;
        if (dut_bus.div_by_zero !== 1'b0 || dut_bus.busy !== 1'b1 || dut_bus.quotient !== 8'hFF) begin
            errors++;
            $display("FAIL dbz_clear dbz=%b busy=%b q=%h expected dbz=0 busy=1 q=ff",
                     dut_bus.div_by_zero, dut_bus.busy, dut_bus.quotient);
        end
        for (int k = 0; k < 8; k++) tick();
        checks++;
        if (dut_bus.done !== 1'b1 || dut_bus.quotient !== 8'd3 || dut_bus.remainder !== 4'd1) begin
            errors++;
            $display("FAIL dbz_next done=%b q=%0d r=%0d expected done=1 q=3 r=1",
                     dut_bus.done, dut_bus.quotient, dut_bus.remainder);
        end
        tick();
    endtask

    task automatic test_ignore_start();
        issue(8'd150, 4'd10);
        tick();
        tick();
        dut_bus.start    = 1'b1;
        dut_bus.dividend = 8'd99;
        dut_bus.divisor  = 4'd3;
        tick();
        dut_bus.start = 1'b0;
        for (int k = 3; k < 8; k++) begin
            checks++;
            if (dut_bus.busy !== 1'b1 || dut_bus.done !== 1'b0) begin
                errors++;
                $display("FAIL ignore_window k=%0d busy=%b done=%b expected busy=1 done=0",
                         k, dut_bus.busy, dut_bus.done);
            end
            tick();
        end
        checks++;
        if (dut_bus.done !== 1'b1 || dut_bus.quotient !== 8'd15 || dut_bus.remainder !== 4'd0) begin
            errors++;
            $display("FAIL ignore_result done=%b q=%0d r=%0d expected done=1 q=15 r=0",
                     dut_bus.done, dut_bus.quotient, dut_bus.remainder);
        end
        tick();
        issue(8'd99, 4'd3);
        for (int k = 1; k < 8; k++) tick();
        checks++;
        if (dut_bus.done !== 1'b0 || dut_bus.quotient !== 8'd15) begin
            errors++;
            $display("FAIL fresh_early done=%b q=%0d expected done=0 q=15", dut_bus.done, dut_bus.quotient);
        end
        tick();
        checks++;
        if (dut_bus.done !== 1'b1 || dut_bus.quotient !== 8'd33 || dut_bus.remainder !== 4'd0) begin
            errors++;
            $display("FAIL fresh_result done=%b q=%0d r=%0d expected done=1 q=33 r=0",
                     dut_bus.done, dut_bus.quotient, dut_bus.remainder);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        dut_bus.start    = 1'b1;
        dut_bus.dividend = 8'd50;
        dut_bus.divisor  = 4'd6;
        tick();
        // start stays high; the new operands must not be recaptured mid-run
        dut_bus.dividend = 8'd121;
        dut_bus.divisor  = 4'd11;
        for (int k = 1; k < 8; k++) tick();
        checks++;
        if (dut_bus.busy !== 1'b1 || dut_bus.done !== 1'b0) begin
            errors++;
            $display("FAIL b2b_window busy=%b done=%b expected busy=1 done=0", dut_bus.busy, dut_bus.done);
        end
        tick();
        checks++;
        if (dut_bus.done !== 1'b1 || dut_bus.quotient !== 8'd8 || dut_bus.remainder !== 4'd2) begin
            errors++;
            $display("FAIL b2b_first done=%b q=%0d r=%0d expected done=1 q=8 r=2",
                     dut_bus.done, dut_bus.quotient, dut_bus.remainder);
        end
        tick();
        dut_bus.start = 1'b0;
        checks++;
        if (dut_bus.done !== 1'b0 || dut_bus.busy !== 1'b1 || dut_bus.quotient !== 8'd8) begin
            errors++;
            $display("FAIL b2b_accept done=%b busy=%b q=%0d expected done=0 busy=1 q=8",
                     dut_bus.done, dut_bus.busy, dut_bus.quotient);
        end
        for (int k = 1; k < 8; k++) tick();
        tick();
        checks++;
        if (dut_bus.done !== 1'b1 || dut_bus.quotient !== 8'd11 || dut_bus.remainder !== 4'd0) begin
            errors++;
            $display("FAIL b2b_second done=%b q=%0d r=%0d expected done=1 q=11 r=0",
                     dut_bus.done, dut_bus.quotient, dut_bus.remainder);
        end
        tick();
        checks++;
        if (dut_bus.done !== 1'b0) begin
            errors++;
            $display("FAIL b2b_pulse done=%b expected 0", dut_bus.done);
        end
    endtask

    task automatic test_reset_mid_run();
        int done_seen;
        issue(8'd240, 4'd9);
        tick();
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        checks++;
        if ({dut_bus.busy, dut_bus.done, dut_bus.div_by_zero} !== 3'b000 ||
            dut_bus.quotient !== 8'd0 || dut_bus.remainder !== 4'd0) begin
            errors++;
            $display("FAIL abort_values busy=%b done=%b dbz=%b q=%0d r=%0d expected all 0",
                     dut_bus.busy, dut_bus.done, dut_bus.div_by_zero, dut_bus.quotient, dut_bus.remainder);
        end
        done_seen = 0;
        tick();
        tick();
        #2 rst_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (dut_bus.done !== 1'b0 || dut_bus.busy !== 1'b0) done_seen++;
        end
        checks++;
        if (done_seen !== 0) begin
            errors++;
            $display("FAIL abort_quiet cycles_with_activity=%0d expected 0", done_seen);
        end
        issue(8'd240, 4'd9);
        for (int k = 1; k < 8; k++) tick();
        tick();
        checks++;
        if (dut_bus.done !== 1'b1 || dut_bus.quotient !== 8'd26 || dut_bus.remainder !== 4'd6) begin
            errors++;
            $display("FAIL abort_rerun done=%b q=%0d r=%0d expected done=1 q=26 r=6",
                     dut_bus.done, dut_bus.quotient, dut_bus.remainder);
        end
    endtask

    // Test sequence and summary.
    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_basic();
        test_latency_pair();
        test_div_by_zero();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid_run();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/restoring_divider.md
Name: restoring_divider

Overview:
- Sequential unsigned radix-2 restoring divider. It is the inverse of the team's combinational 4x4 Booth multiplier.
- Takes an 8-bit magnitude (for example a multiplier product) and a 4-bit divisor. Returns quotient and remainder after a fixed, deterministic latency.
- Sits beside the multiplier so multiply/divide round-trips can be checked on silicon. The core is wrapped by a thin top that maps ui_in/uio_in/uo_out.

Parameters:
- DW, 8, dividend and quotient width.
- VW, 4, divisor and remainder width (VW <= DW).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- start  in  1  request; sampled high on a rising edge while not busy.
- dividend  in  DW  unsigned dividend, captured on the accepted start edge.
- divisor  in  VW  unsigned divisor, captured on the accepted start edge.
- busy  out  1  high while iterating.
- done  out  1  one-cycle pulse when results become valid.
- div_by_zero  out  1  set with done when divisor was 0; held until next accept.
- quotient  out  DW  result, held stable until the next accepted start.
- remainder  out  VW  result, held stable until the next accepted start.

Behaviour:
- Reset (async assert, synchronous-safe deassert): state IDLE; busy, done, div_by_zero = 0; quotient = 0; remainder = 0; iteration counter = 0.
- FSM states: IDLE, RUN, DONE.
- IDLE or DONE, start = 1, divisor != 0:
  - Capture operands.
  - Clear partial remainder, a VW+1-bit register.
  - counter = 0; go to RUN; busy = 1.
- IDLE or DONE, start = 1, divisor == 0:
  - No iteration; go to DONE on that edge.
  - done = 1 and div_by_zero = 1 for the following cycle.
  - quotient = all ones; remainder = 0.
- RUN, one bit per clock, MSB first:
  - Shift the dividend MSB into the partial remainder: pr = {pr[VW-1:0], dvd[DW-1]}.
  - Shift the dividend register left by one.
  - If pr >= divisor: pr = pr - divisor and shift 1 into the quotient LSB; else shift 0.
  - The comparison is unsigned at VW+1 bits.
  - counter increments each cycle. After the DW-th RUN cycle, go to DONE.
  - Load quotient and remainder outputs from the working registers; remainder = pr[VW-1:0], which is always < divisor.
- Latency: start accepted on edge N; outputs valid and done high in the cycle after edge N+DW (N+8 for the defaults). busy is high after edges N+1..N+DW-1 and low from edge N+DW.
- DONE: done drops after one cycle. Outputs hold. The state remains DONE, which is equivalent to IDLE for accepting start.
- start while busy: ignored and not queued; operands are not recaptured.
- start on the same edge done is being presented: accepted (back-to-back). done still pulses for exactly one cycle for the prior result.
- Reset asserted mid-RUN: immediate abort to reset values; no done pulse.
- Working registers are internal. quotient/remainder outputs change only on the transition into DONE.
- dividend == 0 runs the full DW cycles: quotient 0, remainder 0, no shortcut. This keeps the latency constant.

Decomposition:
- Shared package div_pkg holds:
  - the state enum (IDLE/RUN/DONE);
  - localparams DW_DEF = 8 and VW_DEF = 4;
  - CNT_W = $clog2(DW+1).
- Optional sub-module div_step: purely combinational single iteration, taking (pr, dvd_msb, divisor) and returning (pr_next, q_bit). It is instantiated once and reused each cycle.
- The FSM, counter and output registers stay in restoring_divider.

Test Plan:
- 200 / 7 -> after 8 cycles: done = 1, quotient = 28, remainder = 4, div_by_zero = 0; busy high for exactly the iteration window.
- 255 / 15 and 0 / 5 -> quotient = 17, remainder = 0; then quotient = 0, remainder = 0. Same 8-cycle latency both times.
- 9 / 0 -> done one cycle after the accepting edge: div_by_zero = 1, quotient = 0xFF, remainder = 0. Next valid op clears div_by_zero.
- 150 / 10, with start pulsed again with 99 / 3 at cycle 3 of RUN -> the second start is ignored; result is quotient = 15, remainder = 0. A fresh start afterwards gives quotient = 33, remainder = 0.
- Back-to-back: start held high with operands 50 / 6 then 121 / 11 -> quotient 8, remainder 2; then quotient 11, remainder 0. Each done is a single-cycle pulse.
- 240 / 9 with rst_n pulled low at RUN cycle 4 -> all outputs 0 immediately, no done. After release, 240 / 9 gives quotient = 26, remainder = 6.
